gray_ptr_dec: RTL and testbench
===============================

# gray_ptr_dec

Receive-side counterpart of the 9-bit binary-to-Gray encoder in the SDRAM controller's clock-crossing path. The block samples a Gray-coded pointer driven from another clock domain, synchronises it, and decodes it back to binary. It reports each pointer change with its modular delta and flags illegal multi-bit Gray transitions. Its outputs feed the local-domain occupancy and flow-control logic.

## Interface
Parameters:
- W, 9: pointer width in bits; legal range W >= 2.
- SYNC_STAGES, 2: synchroniser depth; legal range >= 2.

Ports:
- CLKGR  in  1: local clock; all logic on the rising edge.
- RSTGR_N  in  1: reset, asynchronous assert, active-low; deassertion is externally synchronised to CLKGR.
- gray_in  in  W: Gray-coded pointer from the foreign domain, asynchronous to CLKGR.
- err_clr  in  1: clears gray_err.
- binary  out  W: decoded pointer, registered.
- bin_valid  out  1: one-cycle pulse when binary takes a new value in RUN.
- bin_delta  out  W: (new binary − previous binary) mod 2^W; updates only with bin_valid, held otherwise.
- gray_err  out  1: sticky flag; set on a synced-sample change with Hamming distance > 1.

## Operation
- Synchroniser: SYNC_STAGES flops in series on gray_in, reset to 0. Only the last stage (gs) is used downstream.
- Decode: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i]. The XOR chain is combinational from gs into the binary register.
- Previous-sample register gp holds the last gs accepted.
- FSM states:
  - FILL: entered on reset; counts SYNC_STAGES cycles so the synchroniser flushes; then goes to ARM.
  - ARM: one cycle. Loads binary = decode(gs) and gp = gs. No bin_valid, no error check. Goes to RUN.
  - RUN: every cycle with gs != gp:
    - binary <= decode(gs), bin_delta <= decode(gs) − binary (mod 2^W), bin_valid <= 1, gp <= gs.
    - If popcount(gs ^ gp) > 1, gray_err <= 1. binary still updates with the decoded value.
  - RUN, gs == gp: bin_valid <= 0; binary, bin_delta and gp hold.
- gray_err is cleared by err_clr on the next edge. If a set and err_clr occur in the same cycle, the set wins.
- Wrap-around: a Gray step from the top code to 0 is a single-bit change. It decodes to 0 with bin_delta = 1 and is not an error.
- Reset mid-operation: all state clears immediately and the FSM restarts in FILL. Any pending change is discarded.

## Timing
- Reset values: binary = 0, bin_valid = 0, bin_delta = 0, gray_err = 0, all synchroniser and gp flops = 0, FSM = FILL.
- After RSTGR_N rises: SYNC_STAGES cycles in FILL, 1 cycle in ARM, then RUN. The first bin_valid can occur no earlier than the cycle after ARM.
- Latency: gray_in captured at edge E0 appears on binary, bin_valid and bin_delta after edge E(SYNC_STAGES), which is 3 edges for the default.
- gray_err asserts in the same cycle as the offending bin_valid.
- Throughput: one accepted change per cycle. Input changes faster than that are the sender's violation and are caught as multi-bit errors.

## Structure
- Shared package gray_pkg:
  - fsm state typedef (FILL, ARM, RUN);
  - gray_to_bin function on a maximum-width vector, truncated by the caller;
  - popcount-greater-than-one helper.
- The binary-to-Gray encoder reuses the same package for its bin_to_gray counterpart.
- One sub-module is natural: gray_sync, a parameterised W-bit, SYNC_STAGES-deep synchroniser with async active-low reset.

## Test plan
- Reset release with gray_in = 9'h1FF held: all outputs 0 during reset. After FILL and ARM, binary = 9'h155, with no bin_valid and no gray_err.
- Gray count 0..511 then wrap to 0, one step every 3 cycles: binary tracks each step 3 edges later with bin_valid pulses and bin_delta = 1 every time, including 511→0. gray_err stays 0.
- Gray input 9'h000 → 9'h003 (two bits flip) in RUN: binary = 9'h002, bin_delta = 9'h002, bin_valid = 1, and gray_err = 1 in the same cycle.
- err_clr pulsed in the same cycle as a new multi-bit error: gray_err stays 1. A later err_clr alone: gray_err = 0 on the next edge.
- gray_in held constant for 20 cycles in RUN: bin_valid stays 0 and binary and bin_delta do not change.
- RSTGR_N pulled low asynchronously between edges mid-count: all outputs go to 0 without waiting for a clock edge. After release, the FSM passes through FILL and ARM before the next bin_valid.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and FSM state type for the SDRAM controller clock-crossing path.
// Functions work on MaxW-bit vectors; callers zero-extend narrower pointers and truncate results.
package gray_pkg;

  localparam int unsigned MaxW = 32;

  typedef enum logic [1:0] {
    StFill,
    StArm,
    StRun
  } fsm_state_e;

  // Zero bits above the caller's width decode to zero, so truncation is exact.
  function automatic logic [MaxW-1:0] gray_to_bin(input logic [MaxW-1:0] g);
    logic [MaxW-1:0] b;
    b[MaxW-1] = g[MaxW-1];
    for (int i = MaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MaxW-1:0] bin_to_gray(input logic [MaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [MaxW-1:0] x);
    return (x & (x - MaxW'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-stage flop synchroniser for a Gray-coded bus arriving from a foreign clock domain.
module gray_sync #(
  parameter int unsigned W           = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_ptr_dec.sv
// Receive-side Gray pointer decoder: synchronises a foreign-domain Gray pointer, decodes it,
// reports each change with its modular delta and flags illegal multi-bit transitions.
module gray_ptr_dec
  import gray_pkg::*;
#(
  parameter int unsigned W           = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         CLKGR,
  input  logic         RSTGR_N,
  input  logic [W-1:0] gray_in,
  input  logic         err_clr,
  output logic [W-1:0] binary,
  output logic         bin_valid,
  output logic [W-1:0] bin_delta,
  output logic         gray_err
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES);
  localparam logic [CntW-1:0] CntLast = CntW'(SYNC_STAGES - 1);

  fsm_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   gs;
  logic [W-1:0]   gp_q, gp_d;
  logic [W-1:0]   binary_q, binary_d;
  logic [W-1:0]   delta_q, delta_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [W-1:0]   gs_dec;
  logic           multi_bit;

  gray_sync #(
    .W           (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_gray_sync (
    .clk_i  (CLKGR),
    .rst_ni (RSTGR_N),
    .d_i    (gray_in),
    .q_o    (gs)
  );

  assign gs_dec    = W'(gray_to_bin(MaxW'(gs)));
  assign multi_bit = popcount_gt1(MaxW'(gs ^ gp_q));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gp_d     = gp_q;
    binary_d = binary_q;
    delta_d  = delta_q;
    valid_d  = 1'b0;
    // A same-cycle error set below overrides the clear.
    err_d    = err_q & ~err_clr;

    unique case (state_q)
      StFill: begin
        if (cnt_q == CntLast) begin
          state_d = StArm;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StArm: begin
        binary_d = gs_dec;
        gp_d     = gs;
        state_d  = StRun;
      end
      StRun: begin
        if (gs != gp_q) begin
          binary_d = gs_dec;
          delta_d  = gs_dec - binary_q;
          valid_d  = 1'b1;
          gp_d     = gs;
          if (multi_bit) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge CLKGR or negedge RSTGR_N) begin
    if (!RSTGR_N) begin
      state_q  <= StFill;
      cnt_q    <= '0;
      gp_q     <= '0;
      binary_q <= '0;
      delta_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gp_q     <= gp_d;
      binary_q <= binary_d;
      delta_q  <= delta_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign binary    = binary_q;
  assign bin_valid = valid_q;
  assign bin_delta = delta_q;
  assign gray_err  = err_q;

endmodule

// File: tb/tb_gray_ptr_dec.sv
// Directed bench for gray_ptr_dec with hand-computed expectations.
module tb_gray_ptr_dec;

  logic       clk;
  logic       rst_n;
  logic [8:0] gray_in;
  logic       err_clr;
  logic [8:0] binary;
  logic       bin_valid;
  logic [8:0] bin_delta;
  logic       gray_err;

  int checks;
  int errors;

  gray_ptr_dec #(
    .W           (9),
    .SYNC_STAGES (2)
  ) dut (
    .CLKGR     (clk),
    .RSTGR_N   (rst_n),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .binary    (binary),
    .bin_valid (bin_valid),
    .bin_delta (bin_delta),
    .gray_err  (gray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [8:0] b, input logic v,
                           input logic [8:0] d, input logic e);
    check_eq({tag, ".binary"}, 32'(binary), 32'(b));
    check_eq({tag, ".valid"}, 32'(bin_valid), 32'(v));
    check_eq({tag, ".delta"}, 32'(bin_delta), 32'(d));
    check_eq({tag, ".err"}, 32'(gray_err), 32'(e));
  endtask

  // Reset, release mid-cycle, and walk through FILL/ARM with gray_in held at g.
  task automatic reset_and_arm(input logic [8:0] g, input logic [8:0] b_armed);
    rst_n   = 1'b0;
    gray_in = g;
    step();
    step();
    check_all("rst", 9'h000, 1'b0, 9'h000, 1'b0);
    #4 rst_n = 1'b1;
    step();
    check_all("fill1", 9'h000, 1'b0, 9'h000, 1'b0);
    step();
    check_all("fill2", 9'h000, 1'b0, 9'h000, 1'b0);
    step();
    check_all("arm", b_armed, 1'b0, 9'h000, 1'b0);
    step();
    check_all("run_idle", b_armed, 1'b0, 9'h000, 1'b0);
  endtask

  initial begin
    logic [8:0] k;
    logic [8:0] g;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    err_clr = 1'b0;
    gray_in = 9'h1FF;
    #2;

    // Gray 1FF decodes to 101010101.
    reset_and_arm(9'h1FF, 9'h155);

    // Full Gray count including the 511 -> 0 wrap.
    reset_and_arm(9'h000, 9'h000);
    for (int i = 1; i <= 512; i++) begin
      k = 9'(i);
      g = k ^ (k >> 1);
      gray_in = g;
      step();
      check_eq("cnt.novalidA", 32'(bin_valid), 32'd0);
      step();
      check_eq("cnt.novalidB", 32'(bin_valid), 32'd0);
      step();
      check_all("cnt", k, 1'b1, 9'h001, 1'b0);
    end

    // Two-bit flip 000 -> 011 decodes to 2 and flags an error.
    gray_in = 9'h003;
    step();
    step();
    step();
    check_all("multi", 9'h002, 1'b1, 9'h002, 1'b1);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("clr1.err", 32'(gray_err), 32'd0);

    // Clear coincides with a new multi-bit error: set wins. 0 - 2 mod 512 = 0x1FE.
    gray_in = 9'h000;
    step();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_all("setwins", 9'h000, 1'b1, 9'h1FE, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("clr2.err", 32'(gray_err), 32'd0);

    // Constant input: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      check_all("hold", 9'h000, 1'b0, 9'h1FE, 1'b0);
    end

    // Async reset between edges right after a valid pulse.
    gray_in = 9'h001;
    step();
    step();
    step();
    check_all("pre_rst", 9'h001, 1'b1, 9'h001, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_all("async_rst", 9'h000, 1'b0, 9'h000, 1'b0);
    step();
    #4 rst_n = 1'b1;
    step();
    check_all("re_fill1", 9'h000, 1'b0, 9'h000, 1'b0);
    step();
    check_all("re_fill2", 9'h000, 1'b0, 9'h000, 1'b0);
    step();
    check_all("re_arm", 9'h001, 1'b0, 9'h000, 1'b0);
    gray_in = 9'h003;
    step();
    step();
    step();
    check_all("re_run", 9'h002, 1'b1, 9'h001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
